// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   SINGLE_WORD / EXCCODE : instruction word and exception-code widths
//   ADEL                  : address-error-on-load/fetch exception code
//   ZEROWORD              : all-zero instruction word, used for exception entries
//   IQ_ENTRY_*            : field widths of one queue entry
//   iq_entry_t            : one queue entry {pc, inst, exc, exc_code}
package inst_fetch_queue_pkg;

    localparam int         SINGLE_WORD = 32;
    localparam int         EXCCODE     = 5;
    localparam logic [4:0] ADEL        = 5'h04;
    localparam logic [31:0] ZEROWORD   = 32'h0;

    localparam int FG_SLOTS        = 4;
    localparam int IQ_ENTRY_PC_W   = SINGLE_WORD;
    localparam int IQ_ENTRY_INST_W = SINGLE_WORD;
    localparam int IQ_ENTRY_EXC_W  = 1;
    localparam int IQ_ENTRY_CODE_W = EXCCODE;
    localparam int IQ_ENTRY_W      = IQ_ENTRY_PC_W + IQ_ENTRY_INST_W
                                   + IQ_ENTRY_EXC_W + IQ_ENTRY_CODE_W;

    typedef struct packed {
        logic [IQ_ENTRY_PC_W-1:0]   pc;
        logic [IQ_ENTRY_INST_W-1:0] inst;
        logic                       exc;
        logic [IQ_ENTRY_CODE_W-1:0] exc_code;
    } iq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fetch_compact.sv
// fetch_compact: combinational 4-to-4 slot compaction of one fetch group.
//   base_vaddr    in  32   group base address (low bits kept only for exceptions)
//   inst_enable   in  4    slot enables
//   insts         in  128  slot i word at [32i+31:32i]
//   has_exception in  1    group carries a fetch exception
//   exc_code      in  5    exception code
//   entries       out 4 x iq_entry_t, enabled slots packed from index 0 upward
//   num           out 3    number of valid entries (0..4)
module fetch_compact
    import inst_fetch_queue_pkg::*;
(
    input  logic [31:0]                      base_vaddr,
    input  logic [FG_SLOTS-1:0]              inst_enable,
    input  logic [FG_SLOTS*SINGLE_WORD-1:0]  insts,
    input  logic                             has_exception,
    input  logic [EXCCODE-1:0]               exc_code,
    output iq_entry_t [FG_SLOTS-1:0]         entries,
    output logic [2:0]                       num
);

    always_comb begin
        entries = '0;
        num     = '0;
        for (int i = 0; i < FG_SLOTS; i++) begin
            if (inst_enable[i]) begin
                entries[num[1:0]].pc       = {base_vaddr[31:4], i[1:0], 2'b00};
                entries[num[1:0]].inst     = insts[SINGLE_WORD*i +: SINGLE_WORD];
                entries[num[1:0]].exc      = 1'b0;
                entries[num[1:0]].exc_code = '0;
                num = num + 3'd1;
            end
        end
        // A faulting fetch delivers a single marker entry carrying the raw
        // address; decode raises the exception when it reaches the head.
        if (has_exception) begin
            entries             = '0;
            entries[0].pc       = base_vaddr;
            entries[0].inst     = ZEROWORD;
            entries[0].exc      = 1'b1;
            entries[0].exc_code = exc_code;
            num                 = 3'd1;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular instruction queue between fetch return and decode.
//   clk, rst              clock, synchronous active-high reset
//   flush_i               redirect: empties the queue next cycle
//   FG_*_i                one 16-byte fetch group per cycle (4 slots + mask + exception)
//   FG_ready_o            at least 4 free entries
//   IQ_stopFetch_o        fewer than 4+STOP_SLACK free entries (throttles PC requests)
//   ID_deqNum_i           entries taken by decode this cycle (0..2)
//   IQ_valid_o/pc/inst/hasException/ExcCode  head and head+1 entries
//   IQ_count_o            occupancy
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PTR_W      = 4,
    parameter int STOP_SLACK = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic                             FG_valid_i,
    input  logic [31:0]                      FG_baseVAddr_i,
    input  logic [FG_SLOTS-1:0]              FG_instEnable_i,
    input  logic [FG_SLOTS*SINGLE_WORD-1:0]  FG_insts_i,
    input  logic                             FG_hasException_i,
    input  logic [EXCCODE-1:0]               FG_ExcCode_i,
    output logic                             FG_ready_o,
    output logic                             IQ_stopFetch_o,
    input  logic [1:0]                       ID_deqNum_i,
    output logic [1:0]                       IQ_valid_o,
    output logic [2*SINGLE_WORD-1:0]         IQ_pc_o,
    output logic [2*SINGLE_WORD-1:0]         IQ_inst_o,
    output logic [1:0]                       IQ_hasException_o,
    output logic [2*EXCCODE-1:0]             IQ_ExcCode_o,
    output logic [PTR_W:0]                   IQ_count_o
);

    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - FG_SLOTS);
    localparam logic [PTR_W:0] STOP_MAX  = (PTR_W+1)'(DEPTH - FG_SLOTS - STOP_SLACK);

    iq_entry_t                mem [DEPTH];
    logic      [PTR_W:0]      rd_ptr, wr_ptr;
    logic      [PTR_W:0]      count;
    iq_entry_t [FG_SLOTS-1:0] cmp_entries;
    logic      [2:0]          cmp_num;
    logic                     enq;
    logic      [1:0]          deq_avail, deq_eff;
    iq_entry_t                head0, head1;

    fetch_compact u_compact (
        .base_vaddr    (FG_baseVAddr_i),
        .inst_enable   (FG_instEnable_i),
        .insts         (FG_insts_i),
        .has_exception (FG_hasException_i),
        .exc_code      (FG_ExcCode_i),
        .entries       (cmp_entries),
        .num           (cmp_num)
    );

    // Extra wrap bit makes the pointer difference the exact occupancy,
    // including the full case (pointers differ only in the wrap bit).
    assign count          = wr_ptr - rd_ptr;
    assign IQ_count_o     = count;
    assign FG_ready_o     = (count <= READY_MAX);
    assign IQ_stopFetch_o = (count > STOP_MAX);

    assign enq       = FG_valid_i && FG_ready_o && !flush_i;
    assign deq_avail = (count >= 2) ? 2'd2 : count[1:0];
    assign deq_eff   = (ID_deqNum_i > deq_avail) ? deq_avail : ID_deqNum_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(deq_eff);
            if (enq)
                wr_ptr <= wr_ptr + (PTR_W+1)'(cmp_num);
        end
    end

    // Storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            for (int j = 0; j < FG_SLOTS; j++) begin
                if (3'(j) < cmp_num)
                    mem[wr_ptr[PTR_W-1:0] + PTR_W'(j)] <= cmp_entries[j];
            end
        end
    end

    assign head0 = mem[rd_ptr[PTR_W-1:0]];
    assign head1 = mem[rd_ptr[PTR_W-1:0] + PTR_W'(1)];

    assign IQ_valid_o        = {count >= 2, count >= 1};
    assign IQ_pc_o           = {head1.pc, head0.pc};
    assign IQ_inst_o         = {head1.inst, head0.inst};
    assign IQ_hasException_o = {head1.exc, head0.exc};
    assign IQ_ExcCode_o      = {head1.exc_code, head0.exc_code};

    // Protocol checks; upstream is expected to honour FG_ready_o / stopFetch.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            assert (!(FG_valid_i && !FG_ready_o))
                else $warning("inst_fetch_queue: fetch group dropped, queue not ready");
            assert (ID_deqNum_i <= deq_avail)
                else $warning("inst_fetch_queue: dequeue beyond valid entries, clamped");
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst, flush_i, FG_valid_i, FG_hasException_i;
    logic [31:0]  FG_baseVAddr_i;
    logic [3:0]   FG_instEnable_i;
    logic [127:0] FG_insts_i;
    logic [4:0]   FG_ExcCode_i;
    logic         FG_ready_o, IQ_stopFetch_o;
    logic [1:0]   ID_deqNum_i, IQ_valid_o, IQ_hasException_o;
    logic [63:0]  IQ_pc_o, IQ_inst_o;
    logic [9:0]   IQ_ExcCode_o;
    logic [4:0]   IQ_count_o;

    inst_fetch_queue dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .FG_valid_i(FG_valid_i), .FG_baseVAddr_i(FG_baseVAddr_i),
        .FG_instEnable_i(FG_instEnable_i), .FG_insts_i(FG_insts_i),
        .FG_hasException_i(FG_hasException_i), .FG_ExcCode_i(FG_ExcCode_i),
        .FG_ready_o(FG_ready_o), .IQ_stopFetch_o(IQ_stopFetch_o),
        .ID_deqNum_i(ID_deqNum_i), .IQ_valid_o(IQ_valid_o),
        .IQ_pc_o(IQ_pc_o), .IQ_inst_o(IQ_inst_o),
        .IQ_hasException_o(IQ_hasException_o), .IQ_ExcCode_o(IQ_ExcCode_o),
        .IQ_count_o(IQ_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  code;
    } ref_t;

    ref_t mq[$];
    int   ncmp = 0;
    int   nbad = 0;

    task automatic cmp(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int n = mq.size();
        cmp({tag, ":count"}, 64'(IQ_count_o), 64'(n));
        cmp({tag, ":valid"}, 64'(IQ_valid_o), {62'd0, n >= 2, n >= 1});
        cmp({tag, ":ready"}, 64'(FG_ready_o), 64'((DEPTH - n) >= 4));
        cmp({tag, ":stop"},  64'(IQ_stopFetch_o), 64'((DEPTH - n) < 8));
        for (int j = 0; j < 2; j++) begin
            if (j < n) begin
                cmp($sformatf("%s:pc%0d", tag, j),   64'(IQ_pc_o[32*j +: 32]), 64'(mq[j].pc));
                cmp($sformatf("%s:inst%0d", tag, j), 64'(IQ_inst_o[32*j +: 32]), 64'(mq[j].inst));
                cmp($sformatf("%s:exc%0d", tag, j),  64'(IQ_hasException_o[j]), 64'(mq[j].exc));
                if (mq[j].exc)
                    cmp($sformatf("%s:code%0d", tag, j), 64'(IQ_ExcCode_o[5*j +: 5]), 64'(mq[j].code));
            end
        end
    endtask

    // One clock with the given inputs; model applies the queue rules afterwards.
    task automatic step(string tag, bit v, logic [31:0] base, logic [3:0] en,
                        bit he, logic [4:0] code, int deq, bit fl);
        int          n   = mq.size();
        int          vc  = (n > 2) ? 2 : n;
        logic [127:0] ins = {$urandom, $urandom, $urandom, $urandom};
        FG_valid_i = v; FG_baseVAddr_i = base; FG_instEnable_i = en;
        FG_insts_i = ins; FG_hasException_i = he; FG_ExcCode_i = code;
        ID_deqNum_i = 2'(deq); flush_i = fl;
        @(posedge clk); #1;
        if (fl) begin
            mq.delete();
        end else begin
            int d = (deq > vc) ? vc : deq;
            repeat (d) void'(mq.pop_front());
            if (v && (DEPTH - n) >= 4) begin
                if (he) mq.push_back('{base, 32'h0, 1'b1, code});
                else begin
                    for (int i = 0; i < 4; i++) begin
                        logic [1:0] s = 2'(i);
                        if (en[i]) mq.push_back('{{base[31:4], s, 2'b00}, ins[32*i +: 32], 1'b0, 5'd0});
                    end
                end
            end
        end
        FG_valid_i = 0; flush_i = 0; ID_deqNum_i = 0; FG_hasException_i = 0;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] fpc;
        rst = 1; flush_i = 0; FG_valid_i = 0; FG_baseVAddr_i = 0; FG_instEnable_i = 0;
        FG_insts_i = 0; FG_hasException_i = 0; FG_ExcCode_i = 0; ID_deqNum_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        mq.delete();
        check_all("reset");
        cmp("reset:count0", 64'(IQ_count_o), 64'd0);

        // full group at boot vector
        step("boot", 1, 32'hBFC00000, 4'b1111, 0, 0, 0, 0);
        cmp("boot:pc0", 64'(IQ_pc_o[31:0]), 64'hBFC00000);
        cmp("boot:pc1", 64'(IQ_pc_o[63:32]), 64'hBFC00004);

        // partial masks compact in order
        step("fl1", 0, 0, 0, 0, 0, 0, 1);
        step("m1100", 1, 32'h80000010, 4'b1100, 0, 0, 0, 0);
        step("m0010", 1, 32'h80000020, 4'b0010, 0, 0, 0, 0);
        cmp("cmpct:pc0", 64'(IQ_pc_o[31:0]), 64'h80000018);
        cmp("cmpct:pc1", 64'(IQ_pc_o[63:32]), 64'h8000001C);
        step("deq2", 0, 0, 0, 0, 0, 2, 0);
        cmp("cmpct:pc2", 64'(IQ_pc_o[31:0]), 64'h80000024);
        step("m0000", 1, 32'h80000030, 4'b0000, 0, 0, 0, 0);

        // fill thresholds
        step("fl2", 0, 0, 0, 0, 0, 0, 1);
        for (int g = 0; g < 3; g++) step("fill", 1, 32'h80001000 + 32'(16*g), 4'b1111, 0, 0, 0, 0);
        cmp("fill12:stop", 64'(IQ_stopFetch_o), 64'd1);
        cmp("fill12:ready", 64'(FG_ready_o), 64'd1);
        step("fill16", 1, 32'h80001030, 4'b1111, 0, 0, 0, 0);
        cmp("fill16:ready", 64'(FG_ready_o), 64'd0);
        step("drop", 1, 32'h80001040, 4'b1111, 0, 0, 0, 0);
        cmp("drop:count", 64'(IQ_count_o), 64'd16);

        // full + enqueue + dequeue + flush: flush wins
        step("fullflush", 1, 32'h80001050, 4'b1111, 0, 0, 2, 1);
        cmp("fullflush:count", 64'(IQ_count_o), 64'd0);
        cmp("fullflush:ready", 64'(FG_ready_o), 64'd1);

        // exception group
        step("exc", 1, 32'h80000002, 4'b1111, 1, ADEL, 0, 0);
        cmp("exc:count", 64'(IQ_count_o), 64'd1);
        cmp("exc:pc", 64'(IQ_pc_o[31:0]), 64'h80000002);
        cmp("exc:inst", 64'(IQ_inst_o[31:0]), 64'd0);
        cmp("exc:code", 64'(IQ_ExcCode_o[4:0]), 64'(ADEL));

        // wrap: stream groups while draining 2 per cycle
        step("fl3", 0, 0, 0, 0, 0, 0, 1);
        fpc = 32'h9000_0000;
        for (int c = 0; c < 20; c++) begin
            bit acc = (DEPTH - mq.size()) >= 4;
            step("wrap", 1, fpc, 4'b1111, 0, 0, 2, 0);
            if (acc) fpc += 32'd16;
        end

        // random traffic, legal dequeue only
        for (int c = 0; c < 400; c++) begin
            int  n  = mq.size();
            int  vc = (n > 2) ? 2 : n;
            bit  v  = ((DEPTH - n) >= 4) && ($urandom_range(3, 0) != 0);
            bit  he = ($urandom_range(15, 0) == 0);
            bit  fl = ($urandom_range(31, 0) == 0);
            step("rand", v, $urandom, 4'($urandom), he, 5'($urandom),
                 int'($urandom_range(vc, 0)), fl);
        end

        // reset mid-operation
        step("pre_rst", 1, 32'hA0000000, 4'b1111, 0, 0, 0, 0);
        rst = 1; FG_valid_i = 1; FG_instEnable_i = 4'b1111;
        @(posedge clk); #1;
        rst = 0; FG_valid_i = 0;
        mq.delete();
        check_all("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
